// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: packs symbolic instructions into 32-bit words,
// expands li into lui/ori, and buffers the result in a show-ahead FIFO.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [4:0]  OP_LI = 5'd29;

  typedef enum logic {S_ONE, S_LI2} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, accept, illegal, push, pop;
  logic [31:0]   enc_word, push_word;
  logic [4:0]    li_rt;
  logic [15:0]   li_lo;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  assign full     = (count == CNT_FULL);
  assign in_ready = (state == S_ONE) && !full;
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_op == 5'd30) || (in_op == 5'd31);
  assign out_valid = (count != '0);
  assign out_instr = mem[rd_ptr];
  assign pop      = out_valid && out_ready;

  // Unused fields are zeroed by construction; nop stays all-zero regardless of inputs.
  always_comb begin
    enc_word = '0;
    case (in_op)
      5'd1:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h20);
      5'd2:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h22);
      5'd3:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h24);
      5'd4:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h25);
      5'd5:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h2A);
      5'd6:  enc_word = r_type(in_rs, in_rt, in_rd, 6'h2B);
      5'd7:  enc_word = r_type(in_rs, 5'd0, 5'd0, 6'h08);
      5'd8:  enc_word = r_type(in_rs, in_rt, 5'd0, 6'h18);
      5'd9:  enc_word = r_type(in_rs, in_rt, 5'd0, 6'h19);
      5'd10: enc_word = r_type(in_rs, in_rt, 5'd0, 6'h1A);
      5'd11: enc_word = r_type(in_rs, in_rt, 5'd0, 6'h1B);
      5'd12: enc_word = r_type(5'd0, 5'd0, in_rd, 6'h10);
      5'd13: enc_word = r_type(5'd0, 5'd0, in_rd, 6'h12);
      5'd14: enc_word = r_type(in_rs, 5'd0, 5'd0, 6'h11);
      5'd15: enc_word = r_type(in_rs, 5'd0, 5'd0, 6'h13);
      5'd16: enc_word = i_type(6'h0D, in_rs, in_rt, in_imm[15:0]);
      5'd17: enc_word = i_type(6'h0F, 5'd0, in_rt, in_imm[15:0]);
      5'd18: enc_word = i_type(6'h08, in_rs, in_rt, in_imm[15:0]);
      5'd19: enc_word = i_type(6'h0C, in_rs, in_rt, in_imm[15:0]);
      5'd20: enc_word = i_type(6'h23, in_rs, in_rt, in_imm[15:0]);
      5'd21: enc_word = i_type(6'h20, in_rs, in_rt, in_imm[15:0]);
      5'd22: enc_word = i_type(6'h21, in_rs, in_rt, in_imm[15:0]);
      5'd23: enc_word = i_type(6'h2B, in_rs, in_rt, in_imm[15:0]);
      5'd24: enc_word = i_type(6'h28, in_rs, in_rt, in_imm[15:0]);
      5'd25: enc_word = i_type(6'h29, in_rs, in_rt, in_imm[15:0]);
      5'd26: enc_word = i_type(6'h04, in_rs, in_rt, in_imm[15:0]);
      5'd27: enc_word = i_type(6'h05, in_rs, in_rt, in_imm[15:0]);
      5'd28: enc_word = {6'h03, in_imm[25:0]};
      5'd29: enc_word = i_type(6'h0F, 5'd0, in_rt, in_imm[31:16]);
      default: enc_word = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_word = enc_word;
    case (state)
      S_ONE: begin
        if (accept && !illegal) begin
          push = 1'b1;
          if (in_op == OP_LI) state_nxt = S_LI2;
        end
      end
      S_LI2: begin
        if (!full) begin
          push      = 1'b1;
          push_word = i_type(6'h0D, li_rt, li_rt, li_lo);
          state_nxt = S_ONE;
        end
      end
      default: state_nxt = S_ONE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_ONE;
      li_rt       <= '0;
      li_lo       <= '0;
      err_illegal <= 1'b0;
      word_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      err_illegal <= accept && illegal;
      if (accept && in_op == OP_LI) begin
        li_rt <= in_rt;
        li_lo <= in_imm[15:0];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        word_count <= word_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded random and directed bench for instr_encoder against a table-driven reference model.
module tb_instr_encoder;

  logic        clk, reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_op, in_rs, in_rt, in_rd;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        err_illegal;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int unsigned total_words = 0;

  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_illegal(err_illegal), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: field-use sets and opcode tables, composed arithmetically.
  function automatic void model(input int unsigned op, input int unsigned rs, input int unsigned rt,
                                input int unsigned rd, input int unsigned imm);
    int unsigned r_funct [16] = '{'h00, 'h20, 'h22, 'h24, 'h25, 'h2A, 'h2B, 'h08,
                                  'h18, 'h19, 'h1A, 'h1B, 'h10, 'h12, 'h11, 'h13};
    int unsigned i_opc [12] = '{'h0D, 'h0F, 'h08, 'h0C, 'h23, 'h20, 'h21, 'h2B,
                                'h28, 'h29, 'h04, 'h05};
    int unsigned w;
    if (op == 0) begin
      exp_q.push_back(0); total_words++;
    end else if (op < 16) begin
      w = r_funct[op];
      if (op inside {[1:11], 14, 15}) w += rs * (1 << 21);
      if (op inside {[1:6], [8:11]})  w += rt * (1 << 16);
      if (op inside {[1:6], 12, 13})  w += rd * (1 << 11);
      exp_q.push_back(w); total_words++;
    end else if (op < 28) begin
      w = i_opc[op-16] * (1 << 26) + rt * (1 << 16) + imm % 65536;
      if (op != 17) w += rs * (1 << 21);
      exp_q.push_back(w); total_words++;
    end else if (op == 28) begin
      exp_q.push_back(3 * (1 << 26) + imm % (1 << 26)); total_words++;
    end else if (op == 29) begin
      exp_q.push_back('h0F * (1 << 26) + rt * (1 << 16) + imm / 65536);
      exp_q.push_back('h0D * (1 << 26) + rt * (1 << 21) + rt * (1 << 16) + imm % 65536);
      total_words += 2;
    end
  endfunction

  // Inputs change at posedge+1; in_ready is sampled at negedge.
  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm, output bit accepted);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 300 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) fail("send_timeout");
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail("unexpected_word");
      else check("out_instr", out_instr, exp_q.pop_front());
    end
  end

  initial begin
    bit ok;
    bit rnd_done;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed encodings.
    out_ready = 1'b1;
    send(5'd1, 5'd1, 5'd2, 5'd3, 32'h0, ok);
    if (ok) begin exp_q.push_back(32'h00221820); total_words++; end
    @(negedge clk);
    check("add_latency_valid", 32'(out_valid), 32'd1);
    drain();
    check("add_word_count", 32'(word_count), 32'd1);

    send(5'd16, 5'd0, 5'd1, 5'd0, 32'h1234, ok);
    if (ok) begin exp_q.push_back(32'h34011234); total_words++; end
    send(5'd23, 5'd29, 5'd5, 5'd0, 32'hFFFC, ok);
    if (ok) begin exp_q.push_back(32'hAFA5FFFC); total_words++; end
    send(5'd12, 5'd7, 5'd7, 5'd4, 32'h0, ok);
    if (ok) begin exp_q.push_back(32'h00002010); total_words++; end
    send(5'd28, 5'd0, 5'd0, 5'd0, 32'hFFFFFC00, ok);
    if (ok) begin exp_q.push_back(32'h0FFFFC00); total_words++; end
    send(5'd7, 5'd31, 5'd0, 5'd9, 32'h0, ok);
    if (ok) begin exp_q.push_back(32'h03E00008); total_words++; end
    drain();

    // li expansion and one-cycle in_ready gap.
    send(5'd29, 5'd0, 5'd8, 5'd0, 32'hDEADBEEF, ok);
    if (ok) begin exp_q.push_back(32'h3C08DEAD); exp_q.push_back(32'h3508BEEF); total_words += 2; end
    @(negedge clk);
    check("li_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("li_ready_back", 32'(in_ready), 32'd1);
    drain();
    check("directed_word_count", 32'(word_count), total_words % 65536);

    // Backpressure: four fill the FIFO, the fifth waits for space.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(5'd1, 5'd1, 5'd2, 5'(k), 32'h0, ok);
      if (ok) model(1, 1, 2, k, 0);
    end
    @(negedge clk);
    check("full_ready_low", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    fork
      begin
        send(5'd1, 5'd1, 5'd2, 5'd5, 32'h0, ok);
        if (ok) model(1, 1, 2, 5, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_word_count", 32'(word_count), total_words % 65536);

    // Illegal op: single pulse, nothing pushed.
    send(5'd31, 5'd3, 5'd3, 5'd3, 32'h12345678, ok);
    @(negedge clk);
    check("illegal_pulse", 32'(err_illegal), 32'd1);
    check("illegal_no_push", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("illegal_pulse_end", 32'(err_illegal), 32'd0);
    check("illegal_no_push2", 32'(out_valid), 32'd0);

    // Reset during a stalled li.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(5'd2, 5'd4, 5'd5, 5'd6, 32'h0, ok);
    end
    send(5'd29, 5'd0, 5'd9, 5'd0, 32'hCAFEF00D, ok);
    @(negedge clk);
    check("li_stall_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midli_rst_valid", 32'(out_valid), 32'd0);
    check("midli_rst_count", 32'(word_count), 32'd0);
    exp_q.delete();
    total_words = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(5'd1, 5'd1, 5'd2, 5'd3, 32'h0, ok);
    if (ok) model(1, 1, 2, 3, 0);
    drain();
    check("post_rst_one_word", 32'(word_count), 32'd1);

    // Random traffic with random consumer stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [4:0] op, rs, rt, rd;
          logic [31:0] imm;
          op = 5'($urandom_range(0, 31));
          rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
          imm = $urandom;
          send(op, rs, rt, rd, imm, ok);
          if (ok) model(op, rs, rt, rd, imm);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_word_count", 32'(word_count), total_words % 65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
